// File: rtl/mem_responder.sv
// Memory-side responder: word RAM plus an I/O window holding a TX FIFO, a status register and a timer.
// Define MEM_TIMER_EN to build the free-running timer at 0xF002; without it that address reads zero.
module mem_responder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        we,
  output logic [15:0] dout,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RAM_WORDS = 1 << ADDR_W;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic io_sel, sel_tx, sel_st, sel_tm;
  assign io_sel = (addr[15:12] == 4'hF);
  assign sel_tx = (addr == 16'hF000);
  assign sel_st = (addr == 16'hF001);
  assign sel_tm = (addr == 16'hF002);

  // RAM contents survive reset, so the array has no reset branch.
  logic [15:0] ram_q [RAM_WORDS];
  always_ff @(posedge clk) begin
    if (we && !io_sel) ram_q[addr[ADDR_W-1:0]] <= din;
  end

  logic [15:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, push, pop, push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign pop     = !empty && tx_ready;
  assign push    = we && sel_tx;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_ok = push && (!full || pop);

  always_comb begin
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d    = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    ovf_d    = ovf_q;
    if (we && sel_st && din[3]) ovf_d = 1'b0;
    if (push && !push_ok)       ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= din;
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 16'h0000 : fifo_q[rd_ptr_q];

  logic [15:0] timer_rd;
`ifdef MEM_TIMER_EN
  logic [15:0] timer_q, timer_d;
  always_comb begin
    timer_d = timer_q + 16'd1;
    if (we && sel_tm) timer_d = din;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
  assign timer_rd = timer_q;
`else
  assign timer_rd = 16'h0000;
`endif

  logic [15:0] status;
  assign status = {12'b0, ovf_q, full, empty, !empty};

  always_comb begin
    dout = 16'h0000;
    if (!io_sel)     dout = ram_q[addr[ADDR_W-1:0]];
    else if (sel_st) dout = status;
    else if (sel_tm) dout = timer_rd;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes model-derived expectations, a negedge monitor compares.
module tb_mem_responder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] addr = 16'h0, din = 16'h0;
  logic        we = 1'b0, tx_ready = 1'b0;
  logic [15:0] dout, tx_data;
  logic        tx_valid;

  mem_responder #(.ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we),
    .dout(dout), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dout;
    logic        tx_valid;
    logic [15:0] tx_data;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0, errors = 0;
  logic [15:0] ram_m [256];
  logic [15:0] fq[$];
  bit          ovf_m = 1'b0;
  logic [15:0] tmr_m = 16'h0;

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a[15:12] != 4'hF) return ram_m[a[7:0]];
    if (a == 16'hF001)
      return {12'b0, ovf_m, fq.size() == DEPTH, fq.size() == 0, fq.size() != 0};
`ifdef MEM_TIMER_EN
    if (a == 16'hF002) return tmr_m;
`endif
    return 16'h0000;
  endfunction

  // One bus cycle: expectation for the pre-edge state, then the model steps across the edge.
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
    exp_t e;
    bit   pop, full, push;
    addr = a; din = d; we = w; tx_ready = r;
    e.dout     = model_read(a);
    e.tx_valid = (fq.size() != 0);
    e.tx_data  = (fq.size() != 0) ? fq[0] : 16'h0000;
    expq.push_back(e);
    pop  = (fq.size() != 0) && r;
    full = (fq.size() == DEPTH);
    push = w && (a == 16'hF000);
    if (w && a == 16'hF001 && d[3]) ovf_m = 1'b0;
    if (push && full && !pop) ovf_m = 1'b1;
    if (pop) void'(fq.pop_front());
    if (push && (!full || pop)) fq.push_back(d);
    if (w && a[15:12] != 4'hF) ram_m[a[7:0]] = d;
    tmr_m = (w && a == 16'hF002) ? d : tmr_m + 16'd1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      check("dout", dout, e.dout);
      check("tx_valid", {15'b0, tx_valid}, {15'b0, e.tx_valid});
      check("tx_data", tx_data, e.tx_data);
    end
  end

  initial begin
    logic [15:0] a;
    int          op;
    #2;
    addr = 16'hF001;
    #1;
    check("rst_tx_valid", {15'b0, tx_valid}, 16'h0);
    check("rst_tx_data", tx_data, 16'h0);
    check("rst_status", dout, 16'h0002);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) cyc(16'(i), 16'($urandom), 1'b1, 1'b0);

    // RAM write/read and upper-bit aliasing
    cyc(16'h0005, 16'h1234, 1'b1, 1'b0);
    cyc(16'h0005, 16'h0, 1'b0, 1'b0);
    cyc(16'h0105, 16'h0, 1'b0, 1'b0);

    // Fill, overflow, then drain one per cycle
    for (int k = 1; k <= 4; k++) cyc(16'hF000, 16'hA000 + 16'(k), 1'b1, 1'b0);
    cyc(16'hF001, 16'h0, 1'b0, 1'b0);
    cyc(16'hF000, 16'hA005, 1'b1, 1'b0);
    cyc(16'hF001, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(16'hF001, 16'h0, 1'b0, 1'b1);
    cyc(16'hF001, 16'h0, 1'b0, 1'b1);

    // Push and pop together at full, then clear overflow
    for (int k = 1; k <= 4; k++) cyc(16'hF000, 16'hB000 + 16'(k), 1'b1, 1'b0);
    cyc(16'hF000, 16'hB005, 1'b1, 1'b1);
    cyc(16'hF001, 16'h0, 1'b0, 1'b0);
    cyc(16'hF001, 16'h0008, 1'b1, 1'b0);
    cyc(16'hF001, 16'h0, 1'b0, 1'b0);

    // Timer load and wrap
    cyc(16'hF002, 16'hFFFE, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(16'hF002, 16'h0, 1'b0, 1'b0);

    // Async reset with three entries pending
    cyc(16'hF001, 16'h0, 1'b0, 1'b1);
    tx_ready = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("arst_tx_valid", {15'b0, tx_valid}, 16'h0);
    check("arst_tx_data", tx_data, 16'h0);
    check("arst_status", dout, 16'h0002);
    fq.delete();
    ovf_m = 1'b0;
    tmr_m = 16'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(16'hF001, 16'h0, 1'b0, 1'b0);
    cyc(16'h0005, 16'h0, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: a = {4'($urandom_range(0, 14)), 4'($urandom), 4'h0, 4'($urandom)};
        2, 3: a = 16'hF000;
        4, 5: a = 16'hF001;
        6:    a = 16'hF002;
        default: a = 16'hF003 + 16'($urandom_range(0, 16'h0FFC));
      endcase
      cyc(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    cyc(16'h0000, 16'h0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 16'(expq.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 16-bit processor's memory port. Answers every `addr`/`we` access from the processor with a word-addressed RAM and a small memory-mapped I/O window. The I/O window holds a transmit FIFO with valid/ready output, a status register and a free-running timer. It sits beside the processor at the top level: processor `addr`/`dout`/`we` drive this block, and its `dout` feeds the processor's `din`.

## Interface
- `ADDR_W`, 8: RAM index width; depth is 2^ADDR_W words; legal range 1..12.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `addr`  in  16  word address from processor.
- `din`  in  16  write data (processor `dout`).
- `we`  in  1  write strobe, sampled at rising `clk`.
- `dout`  out  16  read data (processor `din`).
- `tx_data`  out  16  FIFO head word.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  downstream accepts head when high with `tx_valid`.

## Operation
- Decode:
  - `addr[15:12]==4'hF` selects the I/O region.
  - Otherwise the access goes to RAM at `addr[ADDR_W-1:0]`; upper bits alias.
- RAM:
  - Synchronous write on `we`.
  - Combinational read of `addr`.
  - Contents are not reset.
- I/O map:
  - 0xF000 TXDATA: write pushes `din` into the FIFO. Read returns 0x0000.
  - 0xF001 STATUS: read returns `{12'b0, overflow, full, empty, tx_valid}`. Writing with `din[3]=1` clears `overflow`; other bits are read-only.
  - 0xF002 TIMER: read returns the current count. Write loads `din`.
  - All other 0xFxxx addresses: read 0x0000, writes ignored.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count (0..FIFO_DEPTH).
  - Pop occurs when `tx_valid && tx_ready`.
- Push while full with no pop in the same cycle: the write is dropped and sticky `overflow` is set to 1.
- Push while full with a pop in the same cycle: the push is accepted and the count is unchanged.
- Push while empty: `tx_valid` rises the next cycle; there is no bypass.
- `tx_data` is forced to 0x0000 when the FIFO is empty.
- Timer: 16-bit counter, +1 every cycle, wraps 0xFFFF→0x0000. A write wins over the increment in the same cycle; counting resumes from the loaded value on the next cycle.

## Timing
- Reset values:
  - `dout` reflects the current `addr` (combinational).
  - `tx_valid`=0, `tx_data`=0x0000.
  - FIFO empty, `overflow`=0, timer=0x0000.
- Reset asserted mid-operation immediately empties the FIFO and discards its contents. RAM is untouched.
- Read latency: zero cycles. `dout` is valid in the same cycle as `addr`, so the processor latches it on the next rising edge.
- Write latency: one edge. A read of the same address in the following cycle returns the new value.
- STATUS read in the same cycle as a push or pop returns the pre-edge state.
- FIFO handshake:
  - `tx_data` and `tx_valid` change only on `clk` edges.
  - The downstream may hold `tx_ready` high indefinitely; sustained throughput is one word per cycle.

## Configuration
- `MEM_TIMER_EN` defined: the TIMER register and counter exist as specified.
- `MEM_TIMER_EN` undefined: no counter logic is built, 0xF002 reads 0x0000, and writes to it are ignored.

## Test plan
- RAM: write 0x1234 to 0x0005, then read 0x0005 → `dout`=0x1234. With ADDR_W=8, read 0x0105 → 0x1234 (alias).
- FIFO fill, `tx_ready`=0: push 0xA001..0xA004 → STATUS=0x0005 (full and `tx_valid`). Fifth push 0xA005 → STATUS=0x000D (`overflow` also set). Raise `tx_ready` → 0xA001..0xA004 drain in order, one per cycle, then `tx_valid`=0 and `tx_data`=0x0000.
- Simultaneous push and pop at full → count stays 4, no overflow, new word appears after the existing three. Write 0x0008 to STATUS → `overflow` cleared.
- Timer (`MEM_TIMER_EN`): write 0xFFFE to 0xF002 → reads return 0xFFFE, 0xFFFF, 0x0000 on successive cycles. Without the macro, reads return 0x0000.
- Reset asserted asynchronously with 3 FIFO entries pending → `tx_valid` drops without waiting for a clock edge, STATUS=0x0002, RAM word at 0x0005 is still 0x1234.
